// File: rtl/seg_display_ctrl_pkg.sv
// Shared types and constants for the signed-binary to 7-segment display controller.
// Holds the FSM state encoding, blank/minus patterns and the double-dabble nibble adjust.
package seg_display_ctrl_pkg;

    localparam int VAL_W = 11;
    localparam int DIGITS = 4;
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [3:0] BLANK_CODE = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // One step per magnitude bit, counted 0..VAL_W-1.
    localparam logic [3:0] LAST_STEP = 4'(VAL_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        CONV  = 2'd2,
        LATCH = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_bcdto7seg.sv
// Active-low 7-segment decoder (gfedcba); codes above 9 decode to an unlit digit.
module bcdto7seg
    import seg_display_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Converts a signed 11-bit value to sign + four BCD digits via double-dabble,
// then holds the result on registered digit codes decoded to active-low segments.
//
// state | meaning
// IDLE  | waiting for load; display holds last result
// ABS   | take sign and magnitude of the captured value, clear scratch
// CONV  | one double-dabble step per clock, 11 steps
// LATCH | commit digit codes and sign, pulse done
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter bit LZB = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [6:0]       sign,
    output logic [6:0]       hex3,
    output logic [6:0]       hex2,
    output logic [6:0]       hex1,
    output logic [6:0]       hex0
);

    state_t state_q, state_d;

    logic [VAL_W-1:0]       value_q;
    logic                   neg_q;
    logic [VAL_W-1:0]       mag_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [3:0]             cnt_q;
    logic [DIGITS-1:0][3:0] code_q;
    logic [DIGITS-1:0][3:0] lz_code;
    logic [DIGITS-1:0][6:0] seg;
    logic [6:0]             sign_q;
    logic                   busy_q;
    logic                   done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = ABS;
            ABS:     state_d = CONV;
            CONV:    if (cnt_q == LAST_STEP) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Blank only digits above the highest nonzero one; units always shown.
    always_comb begin
        lz_code = bcd_q;
        if (LZB) begin
            if (bcd_q[15:12] == 4'd0) begin
                lz_code[3] = BLANK_CODE;
                if (bcd_q[11:8] == 4'd0) begin
                    lz_code[2] = BLANK_CODE;
                    if (bcd_q[7:4] == 4'd0) begin
                        lz_code[1] = BLANK_CODE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            code_q  <= {DIGITS{BLANK_CODE}};
            sign_q  <= SEG_BLANK;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        value_q <= value;
                        busy_q  <= 1'b1;
                    end
                end
                ABS: begin
                    // -1024 negates to 1024, which still fits 11 unsigned bits.
                    neg_q <= value_q[VAL_W-1];
                    mag_q <= value_q[VAL_W-1] ? (~value_q + 11'd1) : value_q;
                    bcd_q <= '0;
                    cnt_q <= '0;
                end
                CONV: begin
                    {bcd_q, mag_q} <= {dabble_adjust(bcd_q), mag_q} << 1;
                    cnt_q <= cnt_q + 4'd1;
                end
                LATCH: begin
                    code_q <= lz_code;
                    sign_q <= neg_q ? SEG_MINUS : SEG_BLANK;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcdto7seg u_dec (
            .bcd (code_q[g]),
            .seg (seg[g])
        );
    end

    assign hex3 = seg[3];
    assign hex2 = seg[2];
    assign hex1 = seg[1];
    assign hex0 = seg[0];
    assign sign = sign_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: one instance with leading-zero blanking and one
// without share the same stimulus; expected segment patterns are hand-computed constants.
module tb_seg_display_ctrl;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_MI = 7'b0111111;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_4  = 7'b0011001;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_7  = 7'b1111000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [10:0] value = '0;

    logic       busy, done, busy_z, done_z;
    logic [6:0] sign, hex3, hex2, hex1, hex0;
    logic [6:0] sign_z, hex3_z, hex2_z, hex1_z, hex0_z;

    int n_checks = 0;
    int n_fail = 0;
    logic [6:0] prev_hex0 = S_BL;
    logic [6:0] prev_sign = S_BL;

    always #5 clk = ~clk;

    seg_display_ctrl #(.LZB(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .busy(busy), .done(done), .sign(sign),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    seg_display_ctrl #(.LZB(1'b0)) dut_z (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .busy(busy_z), .done(done_z), .sign(sign_z),
        .hex3(hex3_z), .hex2(hex2_z), .hex1(hex1_z), .hex0(hex0_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_hex3"}, 32'(hex3), 32'(S_BL));
        check({tag, "_hex2"}, 32'(hex2), 32'(S_BL));
        check({tag, "_hex1"}, 32'(hex1), 32'(S_BL));
        check({tag, "_hex0"}, 32'(hex0), 32'(S_BL));
        check({tag, "_sign"}, 32'(sign), 32'(S_BL));
        check({tag, "_hex0_z"}, 32'(hex0_z), 32'(S_BL));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic count_done(input string tag, input int ncyc);
        int pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done || done_z) pulses++;
        end
        check({tag, "_no_done"}, 32'(pulses), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_conv(input string tag, input int v,
                            input logic [6:0] es, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0,
                            input logic [6:0] z3, input logic [6:0] z2, input logic [6:0] z1,
                            input bit inject);
        int cyc = 0;
        bit got = 0;
        @(negedge clk);
        load = 1'b1;
        value = v[10:0];
        @(negedge clk);
        load = 1'b0;
        check({tag, "_busy_set"}, 32'(busy), 32'd1);
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                check({tag, "_hold_hex0"}, 32'(hex0), 32'(prev_hex0));
                check({tag, "_hold_sign"}, 32'(sign), 32'(prev_sign));
                check({tag, "_busy_mid"}, 32'(busy), 32'd1);
                if (inject) begin
                    load = 1'b1;
                    value = 11'h7FB;
                end
            end
            if (cyc == 6) load = 1'b0;
            if (done) got = 1;
        end
        load = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd13);
        check({tag, "_done_z"}, 32'(done_z), 32'd1);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        check({tag, "_sign"}, 32'(sign), 32'(es));
        check({tag, "_hex3"}, 32'(hex3), 32'(e3));
        check({tag, "_hex2"}, 32'(hex2), 32'(e2));
        check({tag, "_hex1"}, 32'(hex1), 32'(e1));
        check({tag, "_hex0"}, 32'(hex0), 32'(e0));
        check({tag, "_sign_z"}, 32'(sign_z), 32'(es));
        check({tag, "_hex3_z"}, 32'(hex3_z), 32'(z3));
        check({tag, "_hex2_z"}, 32'(hex2_z), 32'(z2));
        check({tag, "_hex1_z"}, 32'(hex1_z), 32'(z1));
        check({tag, "_hex0_z"}, 32'(hex0_z), 32'(e0));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_hold_after"}, 32'(hex0), 32'(e0));
        prev_hex0 = e0;
        prev_sign = es;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_blank("reset");
        rst = 1'b0;
        @(negedge clk);
        check_blank("post_reset");

        run_conv("p123",   123, S_BL, S_BL, S_1,  S_2,  S_3, S_0, S_1, S_2, 1'b0);
        run_conv("m1024", -1024, S_MI, S_1,  S_0,  S_2,  S_4, S_1, S_0, S_2, 1'b0);
        run_conv("zero",     0, S_BL, S_BL, S_BL, S_BL, S_0, S_0, S_0, S_0, 1'b0);
        run_conv("p7",       7, S_BL, S_BL, S_BL, S_BL, S_7, S_0, S_0, S_0, 1'b0);
        run_conv("m5",      -5, S_MI, S_BL, S_BL, S_BL, S_5, S_0, S_0, S_0, 1'b0);
        run_conv("p1023", 1023, S_BL, S_1,  S_0,  S_2,  S_3, S_1, S_0, S_2, 1'b1);
        count_done("p1023_ignored", 16);
        check("p1023_kept_hex0", 32'(hex0), 32'(S_3));

        // Abort a conversion of -999 with a reset pulse seven cycles in.
        @(negedge clk);
        load = 1'b1;
        value = 11'h419;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_blank("abort");
        @(negedge clk);
        rst = 1'b0;
        count_done("abort", 16);
        prev_hex0 = S_BL;
        prev_sign = S_BL;

        run_conv("p42", 42, S_BL, S_BL, S_BL, S_4, S_2, S_0, S_0, S_4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
